// File: rtl/vit_enc_pkg.sv
// Shared trellis definition for the convolutional encoder and the Viterbi decoder.
// Both ends import this package, so they agree on K, the generators and the tail length.
package vit_enc_pkg;

    localparam int pCONSTR_LENGTH = 3;
    localparam int pCODE_GEN_NUM  = 2;
    localparam int pTAG_W         = 4;

    // Bit K-1 taps the current input, bit 0 taps the oldest state bit.
    localparam int pCODE_GEN [pCODE_GEN_NUM] = '{6, 7};

    localparam int STATE_NUM = 2 ** (pCONSTR_LENGTH - 1);
    localparam int STATE_W   = $clog2(STATE_NUM);
    localparam int TAIL_LEN  = pCONSTR_LENGTH - 1;
    localparam int TCNT_W    = $clog2(pCONSTR_LENGTH);

    typedef logic [pTAG_W-1:0]         tag_t;
    typedef logic [pCODE_GEN_NUM-1:0]  boutputs_t;
    typedef logic [STATE_W-1:0]        state_t;
    typedef logic [pCONSTR_LENGTH-1:0] treg_t;
    typedef logic [TCNT_W-1:0]         tcnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL
    } fsm_t;

    // Coded symbol for input u leaving state s; generators wider than K are truncated.
    function automatic boutputs_t trellis_out(input logic u, input state_t s);
        treg_t     r;
        boutputs_t o;
        r = {u, s};
        o = '0;
        for (int g = 0; g < pCODE_GEN_NUM; g++) begin
            o[g] = ^(r & treg_t'(pCODE_GEN[g]));
        end
        return o;
    endfunction

    function automatic state_t trellis_next(input logic u, input state_t s);
        treg_t r;
        r = {u, s};
        return state_t'(r >> 1);
    endfunction

endpackage

// File: rtl/vit_enc_if.sv
// Frame-stream bus between the bit source and the encoder, plus the coded-symbol output.
// With VIT_ENC_ERR_INJECT_EN defined, the bus also carries ierr_mask.
interface vit_enc_if;
    import vit_enc_pkg::*;

    logic      isop;
    logic      ival;
    logic      ieop;
    tag_t      itag;
    logic      idat;
`ifdef VIT_ENC_ERR_INJECT_EN
    boutputs_t ierr_mask;
`endif
    logic      ordy;
    logic      osop;
    logic      oval;
    logic      oeop;
    tag_t      otag;
    boutputs_t odat;

    modport slave (
        input  isop, ival, ieop, itag, idat,
`ifdef VIT_ENC_ERR_INJECT_EN
        input  ierr_mask,
`endif
        output ordy, osop, oval, oeop, otag, odat
    );

    modport master (
        output isop, ival, ieop, itag, idat,
`ifdef VIT_ENC_ERR_INJECT_EN
        output ierr_mask,
`endif
        input  ordy, osop, oval, oeop, otag, odat
    );

endinterface

// File: rtl/vit_enc_core.sv
// Shift register plus generator XOR tree; one coded symbol registered per step.
// The XOR mask only perturbs the output symbol, never the trellis state.
module vit_enc_core
    import vit_enc_pkg::*;
(
    input  logic      iclk,
    input  logic      ireset,
    input  logic      iclkena,
    input  logic      istep,
    input  logic      iclear,
    input  logic      iu,
    input  boutputs_t imask,
    output boutputs_t odat
);

    state_t    state_q, state_d, state_cur;
    boutputs_t odat_q, odat_d;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_cur = iclear ? '0 : state_q;
        state_d   = state_q;
        odat_d    = odat_q;
        if (istep) begin
            odat_d  = trellis_out(iu, state_cur) ^ imask;
            state_d = trellis_next(iu, state_cur);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q <= '0;
            odat_q  <= '0;
        end else if (iclkena) begin
            state_q <= state_d;
            odat_q  <= odat_d;
        end
    end

    assign odat = odat_q;

endmodule

// File: rtl/vit_enc.sv
// Terminated-trellis convolutional encoder: frame FSM, tail counter and tag in front of vit_enc_core.
// Optional VIT_ENC_ERR_INJECT_EN XORs bus.ierr_mask into every valid output symbol.
module vit_enc
    import vit_enc_pkg::*;
(
    input  logic     iclk,
    input  logic     ireset,
    input  logic     iclkena,
    vit_enc_if.slave bus
);

    fsm_t      fsm_q;
    tcnt_t     tcnt_q;
    tag_t      otag_q;
    logic      ordy_q;
    logic      osop_q;
    logic      oval_q;
    logic      oeop_q;

    logic      accept;
    logic      step;
    logic      clear;
    logic      u_bit;
    boutputs_t mask;
    boutputs_t core_dat;

`ifdef VIT_ENC_ERR_INJECT_EN
    assign mask = bus.ierr_mask;
`else
    assign mask = '0;
`endif

    assign accept = bus.ival & ordy_q;

    // Tail steps feed zeros regardless of ival; a start of frame clears the state before encoding.
    always_comb begin
        step  = 1'b0;
        clear = 1'b0;
        u_bit = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                if (accept && bus.isop) begin
                    step  = 1'b1;
                    clear = 1'b1;
                    u_bit = bus.idat;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    step  = 1'b1;
                    clear = bus.isop;
                    u_bit = bus.idat;
                end
            end
            ST_TAIL: begin
                step = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            fsm_q  <= ST_IDLE;
            tcnt_q <= '0;
            otag_q <= '0;
            ordy_q <= 1'b1;
            osop_q <= 1'b0;
            oval_q <= 1'b0;
            oeop_q <= 1'b0;
        end else if (iclkena) begin
            osop_q <= step & clear;
            oval_q <= step;
            oeop_q <= 1'b0;
            if (step && clear) begin
                otag_q <= bus.itag;
            end
            unique case (fsm_q)
                ST_IDLE, ST_DATA: begin
                    if (step) begin
                        if (bus.ieop) begin
                            fsm_q  <= ST_TAIL;
                            tcnt_q <= tcnt_t'(TAIL_LEN - 1);
                            ordy_q <= 1'b0;
                        end else begin
                            fsm_q <= ST_DATA;
                        end
                    end
                end
                ST_TAIL: begin
                    if (tcnt_q == '0) begin
                        oeop_q <= 1'b1;
                        fsm_q  <= ST_IDLE;
                        ordy_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q - 1'b1;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    vit_enc_core u_core (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .istep   (step),
        .iclear  (clear),
        .iu      (u_bit),
        .imask   (mask),
        .odat    (core_dat)
    );

    assign bus.ordy = ordy_q;
    assign bus.osop = osop_q;
    assign bus.oval = oval_q;
    assign bus.oeop = oeop_q;
    assign bus.otag = otag_q;
    assign bus.odat = core_dat;

endmodule
